// File: rtl/vram_plane_fetch.sv
// Four-plane VRAM responder: serves 13-bit display word fetches as one atomic
// 32-bit word and owns a one-deep posted CPU write buffer that snoops into vdata.
module vram_plane_fetch #(
    parameter int RD_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [12:0] vaddr,
    output logic [31:0] vdata,
    output logic        fetch_busy,
    // cpu_we is a single-cycle strobe taken only on a cycle where cpu_ready is
    // high; a strobe while cpu_ready is low is dropped with no side effect.
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ready,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic [1:0]  fsm_state
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_DRAIN, S_WR} state_t;

    localparam logic [2:0] LAT  = 3'(RD_LAT);
    localparam logic [2:0] LAST = 3'(RD_LAT + 3);

    state_t      state;
    logic [12:0] cur_addr;
    logic        valid;
    logic [2:0]  step;
    logic [7:0]  s0, s1, s2;
    logic        wb_full;
    logic [14:0] wb_addr;
    logic [7:0]  wb_data;

    logic        trigger;
    logic        wb_take;
    logic        wr_pend;
    logic        capture;
    logic [1:0]  cap_plane;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;

    assign trigger   = ~valid | (vaddr != cur_addr);
    assign wb_take   = cpu_we & ~wb_full;
    assign wr_pend   = wb_full | wb_take;
    // A strobe arriving on the deciding cycle goes straight to WR, bypassing the buffer read.
    assign wr_addr   = wb_full ? wb_addr : cpu_addr;
    assign wr_data   = wb_full ? wb_data : cpu_din;
    // Step counts cycles since the plane 0 issue; plane k lands RD_LAT steps after its issue.
    assign capture   = ((state == S_RD) || (state == S_DRAIN)) && (step >= LAT);
    assign cap_plane = step[1:0] - LAT[1:0];
    assign cpu_ready = ~wb_full;
    assign fsm_state = state;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            valid      <= 1'b0;
            step       <= '0;
            s0         <= '0;
            s1         <= '0;
            s2         <= '0;
            wb_full    <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            vdata      <= '0;
            fetch_busy <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_din    <= '0;
        end else begin
            if (wb_take) begin
                wb_full <= 1'b1;
                wb_addr <= cpu_addr;
                wb_data <= cpu_din;
            end else if (state == S_WR) begin
                wb_full <= 1'b0;
            end

            if (capture) begin
                case (cap_plane)
                    2'd0:    s0 <= mem_dout;
                    2'd1:    s1 <= mem_dout;
                    2'd2:    s2 <= mem_dout;
                    default: vdata <= {s0, s1, s2, mem_dout};
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        cur_addr   <= vaddr;
                        step       <= '0;
                        mem_addr   <= {2'd0, vaddr};
                        fetch_busy <= 1'b1;
                        state      <= S_RD;
                    end else if (wr_pend) begin
                        mem_we   <= 1'b1;
                        mem_addr <= wr_addr;
                        mem_din  <= wr_data;
                        state    <= S_WR;
                    end
                end
                S_RD: begin
                    if (step[1:0] == 2'd3) begin
                        state <= S_DRAIN;
                    end else begin
                        mem_addr <= {step[1:0] + 2'd1, cur_addr};
                    end
                    step <= step + 3'd1;
                end
                S_DRAIN: begin
                    step <= step + 3'd1;
                    if (step == LAST) begin
                        valid      <= 1'b1;
                        fetch_busy <= 1'b0;
                        if (wr_pend) begin
                            mem_we   <= 1'b1;
                            mem_addr <= wr_addr;
                            mem_din  <= wr_data;
                            state    <= S_WR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_WR: begin
                    mem_we <= 1'b0;
                    state  <= S_IDLE;
                    if (valid && (wb_addr[12:0] == cur_addr)) begin
                        case (wb_addr[14:13])
                            2'd0:    vdata[31:24] <= wb_data;
                            2'd1:    vdata[23:16] <= wb_data;
                            2'd2:    vdata[15:8]  <= wb_data;
                            default: vdata[7:0]   <= wb_data;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_plane_fetch.sv
// Bench for vram_plane_fetch: one instance per read latency (1 and 2), each with
// its own VRAM model; directed tables, corner sequences and a random run.
module tb_vram_plane_fetch;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n_a    [2];
    logic [12:0] vaddr_a      [2];
    logic [31:0] vdata_a      [2];
    logic        fetch_busy_a [2];
    logic        cpu_we_a     [2];
    logic [14:0] cpu_addr_a   [2];
    logic [7:0]  cpu_din_a    [2];
    logic        cpu_ready_a  [2];
    logic [14:0] mem_addr_a   [2];
    logic        mem_we_a     [2];
    logic [7:0]  mem_din_a    [2];
    logic [7:0]  mem_dout_a   [2];
    logic [1:0]  fsm_state_a  [2];
    logic        preload_a    [2];
    logic [14:0] peek_addr_a  [2];
    logic [7:0]  peek_data_a  [2];

    int          cur;
    int          n_tests;
    int          n_fail;
    logic [7:0]  exp_mem [0:32767];
    logic [22:0] exp_q[$];
    logic [14:0] wlog[$];

    typedef struct {
        logic [12:0] vaddr;
        logic        exp_busy;
        logic [14:0] exp_maddr;
        logic [31:0] exp_vdata;
    } vec_t;
    vec_t tbl[$];

    // Initial VRAM image: plane number in the top two bits, offset low six bits below.
    function automatic logic [7:0] pat(input logic [14:0] a);
        return 8'(a[14:13]) * 8'h40 + 8'(a & 15'h3F);
    endfunction

    function automatic logic [31:0] word(input logic [12:0] a);
        return {exp_mem[{2'd0, a}], exp_mem[{2'd1, a}], exp_mem[{2'd2, a}], exp_mem[{2'd3, a}]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] ram [0:32767];
        logic [7:0] rd_q1;
        logic [7:0] rd_q2;

        vram_plane_fetch #(.RD_LAT(g + 1)) u_dut (
            .clk_sys    (clk_sys),
            .reset_n    (reset_n_a[g]),
            .vaddr      (vaddr_a[g]),
            .vdata      (vdata_a[g]),
            .fetch_busy (fetch_busy_a[g]),
            .cpu_we     (cpu_we_a[g]),
            .cpu_addr   (cpu_addr_a[g]),
            .cpu_din    (cpu_din_a[g]),
            .cpu_ready  (cpu_ready_a[g]),
            .mem_addr   (mem_addr_a[g]),
            .mem_we     (mem_we_a[g]),
            .mem_din    (mem_din_a[g]),
            .mem_dout   (mem_dout_a[g]),
            .fsm_state  (fsm_state_a[g])
        );

        always @(posedge clk_sys) begin
            if (preload_a[g] === 1'b1) begin
                for (int i = 0; i < 32768; i++) ram[i] = pat(15'(i));
            end else if (mem_we_a[g] === 1'b1) begin
                ram[mem_addr_a[g]] = mem_din_a[g];
            end
            rd_q1 <= ram[mem_addr_a[g]];
            rd_q2 <= rd_q1;
        end
        assign mem_dout_a[g]  = (g == 0) ? rd_q1 : rd_q2;
        assign peek_data_a[g] = ram[peek_addr_a[g]];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s rd_lat=%0d: got %0h expected %0h", nm, cur + 1, act, exp);
        end
    endtask

    task automatic peek(input logic [14:0] a, output logic [7:0] d);
        peek_addr_a[cur] = a;
        #1;
        d = peek_data_a[cur];
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
        chk("wr_ready", cpu_ready_a[cur], 1'b1);
        cpu_we_a[cur]   = 1'b1;
        cpu_addr_a[cur] = a;
        cpu_din_a[cur]  = d;
        exp_q.push_back({a, d});
    endtask

    // Scoreboard for the VRAM write port: every write must match the next accepted CPU write.
    always @(negedge clk_sys) begin
        logic [22:0] e;
        if (reset_n_a[cur] === 1'b1 && mem_we_a[cur] === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected rd_lat=%0d: got write %h<=%h expected none",
                         cur + 1, mem_addr_a[cur], mem_din_a[cur]);
            end else begin
                e = exp_q.pop_front();
                chk("wr_port", {9'd0, mem_addr_a[cur], mem_din_a[cur]}, {9'd0, e});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vdata"}, vdata_a[cur], 32'h0);
        chk({tag, "_busy"}, fetch_busy_a[cur], 1'b0);
        chk({tag, "_ready"}, cpu_ready_a[cur], 1'b1);
        chk({tag, "_maddr"}, mem_addr_a[cur], 15'h0);
        chk({tag, "_mwe"}, mem_we_a[cur], 1'b0);
        chk({tag, "_mdin"}, mem_din_a[cur], 8'h0);
    endtask

    task automatic start_inst();
        reset_n_a[cur]  = 1'b0;
        cpu_we_a[cur]   = 1'b0;
        cpu_addr_a[cur] = '0;
        cpu_din_a[cur]  = '0;
        vaddr_a[cur]    = 13'h0123;
        preload_a[cur]  = 1'b1;
        tick();
        preload_a[cur]  = 1'b0;
        for (int i = 0; i < 32768; i++) exp_mem[i] = pat(15'(i));
        exp_q.delete();
        wlog.delete();
    endtask

    task automatic scen_reset_fetch(input int lat);
        check_reset_outputs("rst");
        tbl.delete();
        for (int k = 1; k <= 5 + lat; k++) begin
            vec_t v;
            v.vaddr     = 13'h0123;
            v.exp_busy  = (k <= 4 + lat);
            v.exp_maddr = (k <= 4) ? {2'(k - 1), 13'h0123} : 15'h6123;
            v.exp_vdata = (k >= 5 + lat) ? 32'h2363A3E3 : 32'h0;
            tbl.push_back(v);
        end
        reset_n_a[cur] = 1'b1;
        foreach (tbl[i]) begin
            vaddr_a[cur] = tbl[i].vaddr;
            tick();
            chk("s1_busy", fetch_busy_a[cur], tbl[i].exp_busy);
            chk("s1_maddr", mem_addr_a[cur], tbl[i].exp_maddr);
            chk("s1_vdata", vdata_a[cur], tbl[i].exp_vdata);
            chk("s1_mwe", mem_we_a[cur], 1'b0);
        end
    endtask

    task automatic scen_retrigger(input int lat);
        logic [31:0] e;
        vaddr_a[cur] = 13'h0100;
        repeat (12) tick();
        chk("s2_pre", vdata_a[cur], word(13'h0100));
        vaddr_a[cur] = 13'h0123;
        for (int k = 1; k <= 10 + 2 * lat; k++) begin
            tick();
            if (k == 2) vaddr_a[cur] = 13'h0124;
            if (k < 5 + lat) e = word(13'h0100);
            else if (k < 10 + 2 * lat) e = word(13'h0123);
            else e = word(13'h0124);
            chk("s2_vdata", vdata_a[cur], e);
        end
    endtask

    task automatic scen_snoop();
        vaddr_a[cur] = 13'h0123;
        repeat (12) tick();
        chk("s3_pre", vdata_a[cur], 32'h2363A3E3);
        cpu_write(15'h4123, 8'hA5);
        tick();
        cpu_we_a[cur] = 1'b0;
        chk("s3_mwe", mem_we_a[cur], 1'b1);
        chk("s3_maddr", mem_addr_a[cur], 15'h4123);
        chk("s3_mdin", mem_din_a[cur], 8'hA5);
        chk("s3_ready_lo", cpu_ready_a[cur], 1'b0);
        exp_mem[15'h4123] = 8'hA5;
        tick();
        chk("s3_mwe_off", mem_we_a[cur], 1'b0);
        chk("s3_ready_hi", cpu_ready_a[cur], 1'b1);
        chk("s3_vdata", vdata_a[cur], 32'h2363A5E3);
    endtask

    task automatic scen_write_during_fetch(input int lat);
        logic [7:0] d;
        vaddr_a[cur] = 13'h0200;
        tick();
        cpu_write(15'h0010, 8'h11);
        tick();
        chk("s4_ready_lo", cpu_ready_a[cur], 1'b0);
        cpu_we_a[cur]   = 1'b1;
        cpu_addr_a[cur] = 15'h0011;
        cpu_din_a[cur]  = 8'h22;
        tick();
        cpu_we_a[cur] = 1'b0;
        for (int k = 3; k <= 4 + lat; k++) begin
            chk("s4_held", mem_we_a[cur], 1'b0);
            tick();
        end
        chk("s4_mwe", mem_we_a[cur], 1'b1);
        chk("s4_maddr", mem_addr_a[cur], 15'h0010);
        chk("s4_mdin", mem_din_a[cur], 8'h11);
        chk("s4_busy", fetch_busy_a[cur], 1'b0);
        exp_mem[15'h0010] = 8'h11;
        repeat (8) tick();
        peek(15'h0010, d);
        chk("s4_ram_0010", d, 8'h11);
        peek(15'h0011, d);
        chk("s4_ram_0011", d, 8'h11);
    endtask

    task automatic scen_fetch_then_write(input int lat);
        vaddr_a[cur] = 13'h0300;
        cpu_write(15'h2300, 8'h5A);
        tick();
        cpu_we_a[cur] = 1'b0;
        chk("s5_busy", fetch_busy_a[cur], 1'b1);
        for (int k = 1; k <= 4 + lat; k++) begin
            chk("s5_no_wr", mem_we_a[cur], 1'b0);
            tick();
        end
        chk("s5_mwe", mem_we_a[cur], 1'b1);
        chk("s5_maddr", mem_addr_a[cur], 15'h2300);
        chk("s5_vdata_new", vdata_a[cur], word(13'h0300));
        exp_mem[15'h2300] = 8'h5A;
        tick();
        chk("s5_vdata_snoop", vdata_a[cur], word(13'h0300));
        chk("s5_ready", cpu_ready_a[cur], 1'b1);
    endtask

    task automatic scen_reset_mid(input int lat);
        logic [7:0] d;
        vaddr_a[cur] = 13'h0400;
        tick();
        cpu_write(15'h0020, 8'h77);
        tick();
        cpu_we_a[cur] = 1'b0;
        chk("s6_ready_lo", cpu_ready_a[cur], 1'b0);
        tick();
        reset_n_a[cur] = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("s6");
        tick();
        tick();
        chk("s6_mwe_rst", mem_we_a[cur], 1'b0);
        reset_n_a[cur] = 1'b1;
        tick();
        chk("s6_refetch_busy", fetch_busy_a[cur], 1'b1);
        chk("s6_refetch_maddr", mem_addr_a[cur], 15'h0400);
        repeat (4 + lat) tick();
        chk("s6_vdata", vdata_a[cur], word(13'h0400));
        peek(15'h0020, d);
        chk("s6_ram_0020", d, 8'h20);
    endtask

    task automatic random_run();
        logic [12:0] va;
        logic [14:0] a;
        logic [7:0]  d;
        int          wr_at;
        int          do_wr;
        for (int it = 0; it < 40; it++) begin
            va    = 13'($urandom_range(0, 8191));
            wr_at = $urandom_range(0, 6);
            do_wr = $urandom_range(0, 1);
            vaddr_a[cur] = va;
            for (int c = 0; c < 16; c++) begin
                if (do_wr == 1 && c == wr_at) begin
                    if ($urandom_range(0, 1) == 1) a = {2'($urandom_range(0, 3)), va};
                    else a = 15'($urandom_range(0, 32767));
                    d = 8'($urandom_range(0, 255));
                    cpu_write(a, d);
                    exp_mem[a] = d;
                    wlog.push_back(a);
                end
                tick();
                cpu_we_a[cur] = 1'b0;
            end
            chk("rand_vdata", vdata_a[cur], word(va));
        end
        foreach (wlog[i]) begin
            peek(wlog[i], d);
            chk("rand_ram", d, exp_mem[wlog[i]]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cur     = 0;
        for (int g = 0; g < 2; g++) begin
            reset_n_a[g]   = 1'b0;
            preload_a[g]   = 1'b0;
            vaddr_a[g]     = '0;
            cpu_we_a[g]    = 1'b0;
            cpu_addr_a[g]  = '0;
            cpu_din_a[g]   = '0;
            peek_addr_a[g] = '0;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            cur = d;
            start_inst();
            scen_reset_fetch(d + 1);
            scen_retrigger(d + 1);
            scen_snoop();
            scen_write_during_fetch(d + 1);
            scen_fetch_then_write(d + 1);
            scen_reset_mid(d + 1);
            random_run();
            repeat (4) tick();
            chk("wr_queue_empty", 32'(exp_q.size()), 32'd0);
            reset_n_a[cur] = 1'b0;
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
